// File: rtl/ppm_pkg.sv
// Shared PPM definitions: FSM state encoding, datapath widths and default timing.
package ppm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace,
        StSync
    } ppm_state_t;

    localparam int unsigned US_W  = 16;
    localparam int unsigned SUM_W = 24;

    // Default timing, common to the transmit encoder and the receive reader.
    localparam int unsigned DEF_TICKS_PER_US = 50;
    localparam int unsigned DEF_FRAME_US     = 22500;
    localparam int unsigned DEF_PULSE_US     = 300;
    localparam int unsigned DEF_CH_MIN_US    = 1000;
    localparam int unsigned DEF_CH_MAX_US    = 2000;
    localparam int unsigned DEF_CH_RESET_US  = 1500;
    localparam int unsigned DEF_MIN_SYNC_US  = 4000;

    function automatic logic [US_W-1:0] clamp_us(
        input logic [US_W-1:0] value,
        input logic [US_W-1:0] lo,
        input logic [US_W-1:0] hi
    );
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every TICKS_PER_MICROSECOND clocks, restartable.
module us_tick_gen
    import ppm_pkg::*;
#(
    parameter int unsigned TICKS_PER_MICROSECOND = DEF_TICKS_PER_US
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (TICKS_PER_MICROSECOND > 1) ? $clog2(TICKS_PER_MICROSECOND) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_MICROSECOND - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap at the last count; clear restarts the microsecond at zero.
    always_comb begin
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ppm_tx_encoder.sv
// PPM frame generator: shadow channel registers committed at frame start, marks and
// spaces timed in microseconds, sync gap padded to the nominal frame length.
module ppm_tx_encoder
    import ppm_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS          = 8,
    parameter int unsigned TICKS_PER_MICROSECOND = DEF_TICKS_PER_US,
    parameter int unsigned FRAME_US              = DEF_FRAME_US,
    parameter int unsigned PULSE_US              = DEF_PULSE_US,
    parameter int unsigned CH_MIN_US             = DEF_CH_MIN_US,
    parameter int unsigned CH_MAX_US             = DEF_CH_MAX_US,
    parameter int unsigned CH_RESET_US           = DEF_CH_RESET_US,
    parameter int unsigned MIN_SYNC_US           = DEF_MIN_SYNC_US,
    parameter bit          IDLE_LEVEL            = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            wr_en,
    input  logic [$clog2(NUM_CHANNELS)-1:0] wr_addr,
    input  logic [15:0]                     wr_data,
    output logic                            ppm_out,
    output logic                            frame_strobe,
    output logic                            busy
);

    localparam int unsigned IDX_W = $clog2(NUM_CHANNELS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS);

    localparam logic [US_W-1:0] PULSE    = US_W'(PULSE_US);
    localparam logic [US_W-1:0] CH_MIN   = US_W'(CH_MIN_US);
    localparam logic [US_W-1:0] CH_MAX   = US_W'(CH_MAX_US);
    localparam logic [US_W-1:0] CH_RST   = US_W'(CH_RESET_US);
    localparam logic [US_W-1:0] MIN_SYNC = US_W'(MIN_SYNC_US);

    localparam logic signed [SUM_W:0] FRAME_S    = (SUM_W + 1)'(FRAME_US);
    localparam logic signed [SUM_W:0] PULSE_S    = (SUM_W + 1)'(PULSE_US);
    localparam logic signed [SUM_W:0] MIN_SYNC_S = (SUM_W + 1)'(MIN_SYNC_US);

    logic [US_W-1:0]     shadow_q [NUM_CHANNELS];
    logic [US_W-1:0]     active_q [NUM_CHANNELS];
    logic [US_W-1:0]     clamped  [NUM_CHANNELS];
    logic [SUM_W-1:0]    chan_sum;
    logic signed [SUM_W:0] gap;
    logic [US_W-1:0]     sync_d;
    logic [US_W-1:0]     sync_q;
    logic [US_W-1:0]     dur_q;
    logic [US_W-1:0]     space_len;
    logic [IDX_W-1:0]    ch_idx_q;
    ppm_state_t          state_q;
    ppm_state_t          state_d;
    logic                us_tick;
    logic                phase_end;
    logic                latch;
    logic                ppm_d;
    logic                strobe_d;
    logic                busy_d;

    us_tick_gen #(
        .TICKS_PER_MICROSECOND(TICKS_PER_MICROSECOND)
    ) u_us_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(latch),
        .tick (us_tick)
    );

    assign phase_end = us_tick && (dur_q == US_W'(1));

    // A frame is committed either from idle or directly at the end of the previous sync.
    assign latch = enable && ((state_q == StIdle) || ((state_q == StSync) && phase_end));

    // Shadow registers take writes in every state; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= CH_RST;
            end
        end else if (wr_en && (32'(wr_addr) < NUM_CHANNELS)) begin
            shadow_q[wr_addr] <= wr_data;
        end
    end

    // Clamped shadow values and their sum, as they would be committed at latch.
    always_comb begin
        chan_sum = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            clamped[i] = clamp_us(shadow_q[i], CH_MIN, CH_MAX);
            chan_sum   = chan_sum + SUM_W'(clamped[i]);
        end
    end

    // Signed gap so an oversubscribed frame falls back to the minimum sync.
    always_comb begin
        gap = FRAME_S - $signed({1'b0, chan_sum}) - PULSE_S;
        if (gap < MIN_SYNC_S) begin
            sync_d = MIN_SYNC;
        end else begin
            sync_d = US_W'(gap);
        end
    end

    // Space length for the current channel (mark-to-mark equals the channel width).
    always_comb begin
        space_len = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_idx_q == IDX_W'(i)) begin
                space_len = active_q[i] - PULSE;
            end
        end
    end

    // Frame datapath: active channels, sync length, channel index and duration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                active_q[i] <= CH_RST;
            end
            sync_q   <= MIN_SYNC;
            dur_q    <= '0;
            ch_idx_q <= '0;
        end else if (latch) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                active_q[i] <= clamped[i];
            end
            sync_q   <= sync_d;
            ch_idx_q <= '0;
            dur_q    <= PULSE;
        end else if (phase_end) begin
            case (state_q)
                StMark:  dur_q <= (ch_idx_q < LAST_IDX) ? space_len : sync_q;
                StSpace: begin
                    ch_idx_q <= ch_idx_q + IDX_W'(1);
                    dur_q    <= PULSE;
                end
                default: ;
            endcase
        end else if (us_tick && (state_q != StIdle)) begin
            dur_q <= dur_q - US_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (enable) state_d = StMark;
            StMark:  if (phase_end) state_d = (ch_idx_q < LAST_IDX) ? StSpace : StSync;
            StSpace: if (phase_end) state_d = StMark;
            StSync:  if (phase_end) state_d = enable ? StMark : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output next values; outputs change on the same edge as the state.
    always_comb begin
        ppm_d    = ppm_out;
        strobe_d = 1'b0;
        busy_d   = busy;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    ppm_d    = ~IDLE_LEVEL;
                    strobe_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            StMark:  if (phase_end) ppm_d = IDLE_LEVEL;
            StSpace: if (phase_end) ppm_d = ~IDLE_LEVEL;
            StSync: begin
                if (phase_end) begin
                    if (enable) begin
                        ppm_d    = ~IDLE_LEVEL;
                        strobe_d = 1'b1;
                    end else begin
                        busy_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ppm_out      <= IDLE_LEVEL;
            frame_strobe <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ppm_out      <= ppm_d;
            frame_strobe <= strobe_d;
            busy         <= busy_d;
        end
    end

endmodule
